// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai21_bist.sv
// Built-in self test for the OAI21 cell: walks {A1,A2,B} through all eight vectors,
// compares ZN against !((A1|A2)&B) and reports a saturating error count and the first failing vector.
module gf180mcu_fd_sc_mcu7t5v0__oai21_bist #(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1,
    parameter int ERR_W  = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    output logic             A1,
    output logic             A2,
    output logic             B,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL_SEEN,
    output logic [2:0]       FAIL_VEC,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int                LOOP_W    = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
    localparam logic [3:0]        WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t              state_q, state_d;
    logic [2:0]          vec_q, vec_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic [3:0]          wait_q, wait_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fseen_q, fseen_d;
    logic [2:0]          fvec_q, fvec_d;
    logic                pass_q, pass_d;

    logic last_vec;
    logic zn_exp;
    logic mismatch;

    assign last_vec = (vec_q == 3'd7) && (loop_q == LAST_LOOP);
    assign zn_exp   = !((vec_q[2] | vec_q[1]) & vec_q[0]);

    // NOTE: registers use non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= S_IDLE;
            vec_q   <= 3'd0;
            loop_q  <= '0;
            wait_q  <= 4'd0;
            err_q   <= '0;
            fseen_q <= 1'b0;
            fvec_q  <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fseen_q <= fseen_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
        end
    end

    // NOTE: each combinational block assigns a default to every output first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (START) state_d = S_APPLY;
            S_APPLY:  state_d = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            S_WAIT:   if (wait_q == 4'd0) state_d = S_SAMPLE;
            S_SAMPLE: state_d = last_vec ? S_DONE : S_APPLY;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Case inequality so an X or Z response is treated as a failure, not silently matched.
    always_comb begin
        vec_d    = vec_q;
        loop_d   = loop_q;
        wait_d   = wait_q;
        err_d    = err_q;
        fseen_d  = fseen_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        mismatch = (state_q == S_SAMPLE) && (ZN !== zn_exp);
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    vec_d   = 3'd0;
                    loop_d  = '0;
                    err_d   = '0;
                    fseen_d = 1'b0;
                    fvec_d  = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: wait_d = WAIT_LOAD;
            S_WAIT: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (!fseen_q) begin
                        fseen_d = 1'b1;
                        fvec_d  = vec_q;
                    end
                end
                if (last_vec) begin
                    vec_d  = 3'd0;
                    pass_d = (err_d == '0);
                end else begin
                    vec_d = vec_q + 3'd1;
                    if (vec_q == 3'd7) loop_d = loop_q + LOOP_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_APPLY, S_WAIT, S_SAMPLE: BUSY = 1'b1;
            S_DONE:                    DONE = 1'b1;
            default: ;
        endcase
    end

    assign A1        = vec_q[2];
    assign A2        = vec_q[1];
    assign B         = vec_q[0];
    assign ERR_CNT   = err_q;
    assign FAIL_SEEN = fseen_q;
    assign FAIL_VEC  = fvec_q;
    assign PASS      = pass_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__oai21_bist.md
GF180MCU_FD_SC_MCU7T5V0__OAI21_BIST -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__oai21_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the wait cycles between driving a vector and sampling ZN (legal 0..15).
REQ-002 The block SHALL have parameter LOOPS, default 1, giving the full passes over the 8-vector space (legal >= 1).
REQ-003 The block SHALL have parameter ERR_W, default 4, giving the error counter width (legal 1..16).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-005 The ports SHALL be, in order:
- CLK  in  1  clock; rising edge.
- R  in  1  asynchronous active-high reset.
- START  in  1  request a test run.
- A1  out  1  stimulus to the cell under test.
- A2  out  1  stimulus to the cell under test.
- B  out  1  stimulus to the cell under test.
- ZN  in  1  response from the cell under test.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle end-of-run pulse.
- PASS  out  1  last run had zero mismatches.
- FAIL_SEEN  out  1  at least one mismatch this run.
- FAIL_VEC  out  3  {A1,A2,B} of the first mismatch.
- ERR_CNT  out  ERR_W  saturating mismatch count.

Function
REQ-006 The expected response SHALL be ZN_exp = !((A1 | A2) & B).
REQ-007 The FSM SHALL have the states IDLE, APPLY, WAIT, SAMPLE and DONE; each state SHALL last one cycle, except WAIT, which lasts SETTLE cycles.
REQ-008 The FSM transitions SHALL be:
- IDLE to APPLY when START=1.
- APPLY to WAIT when SETTLE>0, else APPLY to SAMPLE.
- WAIT to SAMPLE when its counter reaches 0.
- SAMPLE to APPLY with the next vector, or SAMPLE to DONE after vector 7 of loop LOOPS-1.
- DONE to IDLE unconditionally.
REQ-009 Vectors SHALL be issued as {A1,A2,B} = 3'b000, 001, ... 111 in ascending order, repeated LOOPS times.
REQ-010 A1, A2 and B SHALL be registered outputs, updated on entry to APPLY and held through WAIT and SAMPLE; they SHALL be 000 in IDLE and DONE.
REQ-011 In SAMPLE, ZN SHALL be compared to ZN_exp using case inequality, so that X or Z on ZN counts as a mismatch.
REQ-012 On each mismatch, ERR_CNT SHALL increment and saturate at 2^ERR_W-1.
REQ-013 On the first mismatch of a run, FAIL_SEEN SHALL be set and FAIL_VEC SHALL capture the current vector; later mismatches SHALL NOT alter FAIL_VEC.
REQ-014 BUSY SHALL be 1 in APPLY, WAIT and SAMPLE, and 0 otherwise.
REQ-015 DONE SHALL be 1 only in the DONE state.
REQ-016 With START sampled high at edge k, DONE SHALL be high in cycle k+1+8*LOOPS*(2+SETTLE).
REQ-017 On the IDLE-to-APPLY edge, ERR_CNT, FAIL_SEEN, FAIL_VEC and PASS SHALL be cleared.
REQ-018 PASS SHALL be loaded with (ERR_CNT==0), including the final sample, on entry to DONE and held until the next accepted START.
REQ-019 START SHALL be ignored in APPLY, WAIT, SAMPLE and DONE; if START is held high continuously, a new run SHALL begin from IDLE one cycle after DONE.
REQ-020 ERR_CNT, FAIL_VEC and FAIL_SEEN SHALL hold their values after DONE until the next accepted START.

Reset
REQ-021 While R=1, the block SHALL immediately, without waiting for CLK, enter IDLE and drive all outputs to 0: A1/A2/B=000, BUSY=0, DONE=0, PASS=0, FAIL_SEEN=0, FAIL_VEC=000, ERR_CNT=0.
REQ-022 Assertion of R mid-run SHALL abort the run with no DONE pulse.
REQ-023 After R is released, the first accepted START SHALL begin from vector 000, loop 0.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Golden DUT, SETTLE=2, LOOPS=1, START pulsed at edge 0 -> vectors 000..111 each held 4 cycles; DONE in cycle 33; PASS=1; ERR_CNT=0; FAIL_SEEN=0.
- ZN stuck-at-0, defaults -> mismatches at 000, 001, 010, 100, 110; ERR_CNT=5; FAIL_VEC=000; PASS=0; FAIL_SEEN=1.
- ZN stuck-at-1, LOOPS=2, ERR_W=2 -> 6 mismatches (011, 101, 111 per loop); ERR_CNT saturates at 3; FAIL_VEC=011; PASS=0.
- R asserted while vector 100 is driven -> all outputs 0 within the same cycle, no DONE; a subsequent START gives a full run ending PASS=1 on the golden DUT.
- START held high, SETTLE=0, golden DUT -> first DONE in cycle 17; START ignored while BUSY; second run's APPLY one cycle after DONE; PASS cleared at second start, then reloaded to 1.
- ZN driven X on vector 101 only -> ERR_CNT=1; FAIL_VEC=101; PASS=0.
